// File: rtl/mcr_mem_pkg.sv
// mcr_mem_pkg: shared types for the toggle-port responder and its request FIFO
package mcr_mem_pkg;
  localparam int CMD_AW = 23;
  localparam logic [1:0] DS_NONE = 2'b00;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} resp_state_t;
  typedef struct packed {
    logic [CMD_AW-1:0] addr;
    logic [1:0]        ds;
    logic              we;
    logic [15:0]       wdata;
  } port_cmd_t;
endpackage

// File: rtl/sdram_port_responder_if.sv
// sdram_port_responder_if: toggle request port plus valid/ready memory command bus
interface sdram_port_responder_if #(parameter int AW = 23) ();
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [15:0]   port_d;
  logic [15:0]   port_q;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_ds;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic          mem_rvalid;
  logic [15:0]   mem_rdata;
  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d, mem_ready, mem_rvalid, mem_rdata,
    output port_ack, port_q, mem_valid, mem_addr, mem_ds, mem_we, mem_wdata
  );
  modport master (
    output port_req, port_a, port_ds, port_we, port_d, mem_ready, mem_rvalid, mem_rdata,
    input  port_ack, port_q, mem_valid, mem_addr, mem_ds, mem_we, mem_wdata
  );
endinterface

// File: rtl/sdram_port_responder_req_fifo.sv
// req_fifo: synchronous command FIFO with registered occupancy count
module req_fifo
  import mcr_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  port_cmd_t i_data,
  input  logic      i_pop,
  output port_cmd_t o_head,
  output logic      o_full,
  output logic      o_empty
);
  localparam int PW = $clog2(DEPTH);
  port_cmd_t r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (PW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_head = r_mem[r_rd];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
endmodule

// File: rtl/sdram_port_responder.sv
// sdram_port_responder: toggle req/ack port captured into a FIFO and replayed onto a valid/ready memory bus
module sdram_port_responder
  import mcr_mem_pkg::*;
#(
  parameter int AW         = CMD_AW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  sdram_port_responder_if.slave  bus,
  output logic                   busy,
  output logic                   overflow
);
  resp_state_t r_state, w_state_nx;
  logic r_init, r_req_seen, r_req_d, r_rd_block, r_ack, r_overflow;
  logic [15:0] r_q;
  logic [AW-1:0] w_addr;
  port_cmd_t w_cmd, w_head;
  logic w_pending, w_accept, w_full, w_empty, w_noop, w_valid, w_fire, w_pop, w_rdone;
  assign w_addr = bus.port_a;
  assign w_cmd = '{addr: w_addr, ds: bus.port_ds, we: bus.port_we, wdata: bus.port_d};
  assign w_pending = r_init && (bus.port_req != r_req_seen);
  assign w_accept = w_pending && !w_full && !r_rd_block;
  assign w_noop = w_head.ds == DS_NONE;
  assign w_valid = !w_empty && !w_noop && r_state != RDWAIT;
  assign w_fire = w_valid && bus.mem_ready;
  assign w_pop = w_fire || (!w_empty && w_noop && r_state == IDLE);
  assign w_rdone = r_state == RDWAIT && bus.mem_rvalid;
  req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_sys), .rst(reset), .i_push(w_accept), .i_data(w_cmd), .i_pop(w_pop),
    .o_head(w_head), .o_full(w_full), .o_empty(w_empty)
  );
  always_comb begin
    w_state_nx = r_state == RDWAIT ? (bus.mem_rvalid ? IDLE : RDWAIT)
               : w_fire ? (w_head.we ? IDLE : RDWAIT)
               : w_valid ? ISSUE : IDLE;
    bus.mem_valid = w_valid;
    bus.mem_addr = w_valid ? w_head.addr : '0;
    bus.mem_ds = w_valid ? w_head.ds : '0;
    bus.mem_we = w_valid && w_head.we;
    bus.mem_wdata = w_valid ? w_head.wdata : '0;
  end
  // a second req edge before the first was taken cancels the pair and is flagged
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_init <= 1'b0;
      r_req_seen <= 1'b0;
      r_req_d <= 1'b0;
      r_rd_block <= 1'b0;
      r_ack <= 1'b0;
      r_overflow <= 1'b0;
      r_q <= '0;
    end else begin
      r_state <= w_state_nx;
      r_init <= 1'b1;
      r_req_d <= bus.port_req;
      if (!r_init || w_accept) r_req_seen <= bus.port_req;
      if (r_init && bus.port_req != r_req_d && r_req_d != r_req_seen) r_overflow <= 1'b1;
      if (w_accept && !w_cmd.we && w_cmd.ds != DS_NONE) r_rd_block <= 1'b1;
      else if (w_rdone) r_rd_block <= 1'b0;
      if (w_rdone) r_q <= bus.mem_rdata;
      r_ack <= r_ack ^ (w_accept && (w_cmd.we || w_cmd.ds == DS_NONE)) ^ w_rdone;
    end
  assign bus.port_ack = r_ack;
  assign bus.port_q = r_q;
  assign overflow = r_overflow;
  assign busy = !w_empty || r_state != IDLE || r_rd_block;
endmodule

// File: tb/tb_sdram_port_responder.sv
// tb_sdram_port_responder: directed vectors with hand-computed expectations
module tb_sdram_port_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, overflow;
  int n_chk = 0;
  int n_err = 0;
  int n_ack = 0;
  logic ack_d = 1'b0;
  logic [41:0] log_q[$];
  int ab, lb;
  logic a0;
  sdram_port_responder_if #(.AW(23)) bus ();
  sdram_port_responder #(.AW(23), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk), .reset(rst), .bus(bus), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && bus.mem_valid && bus.mem_ready)
      log_q.push_back({bus.mem_addr, bus.mem_we, bus.mem_ds, bus.mem_wdata});
    if (bus.port_ack != ack_d) n_ack++;
    ack_d = bus.port_ack;
  end
  function automatic logic [41:0] cmd(logic [22:0] a, logic we, logic [1:0] ds, logic [15:0] d);
    return {a, we, ds, d};
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(logic [22:0] a, logic [1:0] ds, logic we, logic [15:0] d);
    bus.port_a = a;
    bus.port_ds = ds;
    bus.port_we = we;
    bus.port_d = d;
    bus.port_req = ~bus.port_req;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [22:0] ba [3];
    logic [15:0] bd [3];
    ba = '{23'h10, 23'h11, 23'h12};
    bd = '{16'hA5A5, 16'h5A5A, 16'h1234};
    bus.port_req = 1'b0; bus.port_a = '0; bus.port_ds = '0; bus.port_we = 1'b0; bus.port_d = '0;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    #2 rst = 1'b1;
    step(2);
    chk("rst_ack", bus.port_ack, 0);
    chk("rst_q", bus.port_q, 0);
    chk("rst_valid", bus.mem_valid, 0);
    chk("rst_cmd", {bus.mem_addr, bus.mem_ds, bus.mem_we, bus.mem_wdata}, 0);
    chk("rst_busy_ovf", {busy, overflow}, 0);
    rst = 1'b0;
    step();
    // write burst, ready tied high
    step(); req(ba[0], 2'b11, 1'b1, bd[0]); #1;
    chk("burst_no_early_valid", bus.mem_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) req(ba[i+1], 2'b11, 1'b1, bd[i+1]);
      #1;
      chk("burst_ack", bus.port_ack, 64'(i % 2 == 0));
      chk("burst_valid", bus.mem_valid, 1);
      chk("burst_addr", bus.mem_addr, ba[i]);
      chk("burst_wdata", bus.mem_wdata, bd[i]);
      chk("burst_we_ds", {bus.mem_we, bus.mem_ds}, 3'b111);
    end
    step(); #1;
    chk("burst_drained", {bus.mem_valid, busy, bus.port_ack}, 3'b001);
    chk("burst_log_n", log_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("burst_log", log_q[i], cmd(ba[i], 1'b1, 2'b11, bd[i]));
    // backpressure: 4 fill the FIFO, the 5th waits
    bus.mem_ready = 1'b0; ab = n_ack; lb = log_q.size();
    for (int i = 0; i < 5; i++) begin
      step(); req(23'h100 + 23'(i), 2'b11, 1'b1, 16'h1000 + 16'(i));
      step(2);
    end
    #1;
    chk("bp_acks_held", n_ack - ab, 4);
    chk("bp_no_cmd", log_q.size() - lb, 0);
    chk("bp_head", {bus.mem_valid, bus.mem_addr}, {1'b1, 23'h100});
    chk("bp_busy_ovf", {busy, overflow}, 2'b10);
    bus.mem_ready = 1'b1;
    step(10);
    chk("bp_acks_all", n_ack - ab, 5);
    chk("bp_cmd_n", log_q.size() - lb, 5);
    for (int i = 0; i < 5; i++)
      chk("bp_log", log_q[lb+i], cmd(23'h100 + 23'(i), 1'b1, 2'b11, 16'h1000 + 16'(i)));
    chk("bp_ovf", overflow, 0);
    // read after write, with a toggle held behind the read
    lb = log_q.size();
    step(); req(23'h20, 2'b11, 1'b1, 16'hBEEF);
    step(); req(23'h20, 2'b11, 1'b0, 16'h0000);
    step(); a0 = bus.port_ack; req(23'h21, 2'b11, 1'b1, 16'h7777); #1;
    chk("rd_issue", {bus.mem_valid, bus.mem_we, bus.mem_addr}, {2'b10, 23'h20});
    step(); #1;
    chk("rd_wait", {bus.mem_valid, busy}, 2'b01);
    step();
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hBEEF; #1;
    chk("rd_q_before", bus.port_q, 0);
    step(); bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; #1;
    chk("rd_q", bus.port_q, 16'hBEEF);
    chk("rd_ack", bus.port_ack, !a0);
    chk("rd_held_not_yet", bus.mem_valid, 0);
    step(); #1;
    chk("rd_held_issue", {bus.mem_valid, bus.mem_addr}, {1'b1, 23'h21});
    chk("rd_held_ack", bus.port_ack, a0);
    step(2);
    chk("rd_log0", log_q[lb], cmd(23'h20, 1'b1, 2'b11, 16'hBEEF));
    chk("rd_log1", log_q[lb+1], cmd(23'h20, 1'b0, 2'b11, 16'h0000));
    chk("rd_log2", log_q[lb+2], cmd(23'h21, 1'b1, 2'b11, 16'h7777));
    a0 = bus.port_ack;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hDEAD;
    step(); bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; #1;
    chk("stray_rvalid_q", bus.port_q, 16'hBEEF);
    chk("stray_rvalid_ack", bus.port_ack, a0);
    // overflow: two edges while full
    bus.mem_ready = 1'b0; ab = n_ack; lb = log_q.size();
    for (int i = 0; i < 4; i++) begin
      step(); req(23'h300 + 23'(i), 2'b11, 1'b1, 16'h3000 + 16'(i));
    end
    step(); req(23'h3FF, 2'b11, 1'b1, 16'hFFFF);
    step(); bus.port_req = ~bus.port_req; #1;
    chk("ovf_not_yet", overflow, 0);
    step(); #1;
    chk("ovf_set", overflow, 1);
    step(2);
    chk("ovf_acks", n_ack - ab, 4);
    bus.mem_ready = 1'b1;
    step(8);
    chk("ovf_cmd_n", log_q.size() - lb, 4);
    chk("ovf_last", log_q[log_q.size()-1], cmd(23'h303, 1'b1, 2'b11, 16'h3003));
    chk("ovf_sticky", {overflow, busy}, 2'b10);
    chk("ovf_acks_after", n_ack - ab, 4);
    // no-op requests, write and read flavoured
    ab = n_ack; lb = log_q.size();
    step(); req(23'h40, 2'b00, 1'b1, 16'h1111); #1;
    chk("noop_w_valid0", bus.mem_valid, 0);
    step(); #1;
    chk("noop_w_valid1", bus.mem_valid, 0);
    step(); req(23'h41, 2'b00, 1'b0, 16'h0000); #1;
    chk("noop_r_valid0", bus.mem_valid, 0);
    step(); #1;
    chk("noop_r_valid1", bus.mem_valid, 0);
    step(2);
    chk("noop_acks", n_ack - ab, 2);
    chk("noop_no_cmd", log_q.size() - lb, 0);
    chk("noop_idle", busy, 0);
    // reset with port_req high and two entries queued
    bus.mem_ready = 1'b0;
    step(); req(23'h400, 2'b11, 1'b1, 16'h4444);
    step(); req(23'h401, 2'b11, 1'b1, 16'h4445);
    step(); #1;
    chk("pre_rst", {bus.mem_valid, busy}, 2'b11);
    rst = 1'b1; #1;
    chk("arst_ack_q", {bus.port_ack, bus.port_q}, 0);
    chk("arst_cmd", {bus.mem_valid, bus.mem_addr, bus.mem_ds, bus.mem_we, bus.mem_wdata}, 0);
    chk("arst_busy_ovf", {busy, overflow}, 0);
    step(2); rst = 1'b0; bus.mem_ready = 1'b1; ab = n_ack; lb = log_q.size();
    step(4); #1;
    chk("post_rst_no_cmd", log_q.size() - lb, 0);
    chk("post_rst_no_ack", n_ack - ab, 0);
    chk("post_rst_idle", {bus.mem_valid, busy}, 0);
    step(); req(23'h500, 2'b11, 1'b1, 16'h5555);
    step(); #1;
    chk("post_rst_cmd", {bus.mem_valid, bus.mem_addr, bus.mem_wdata}, {1'b1, 23'h500, 16'h5555});
    chk("post_rst_ack", bus.port_ack, 1);
    step(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
